// File: rtl/prach_pkg.sv
// Shared PRACH constants: channel count, HB3 coefficient pair and
// arithmetic helpers used by the hb3 decimator/interpolator pair.
package prach_pkg;

    localparam int unsigned NumChannelUsed = 48;
    localparam int unsigned Latency        = 6;

    localparam logic signed [17:0] CoeA = -18'sd4750;
    localparam logic signed [17:0] CoeB = 18'sd37456;

    typedef enum logic {
        SEQ_HUNT,
        SEQ_TRACK
    } seq_state_e;

    function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
        if (v > 20'sd32767) begin
            return 16'sd32767;
        end else if (v < -20'sd32768) begin
            return -16'sd32768;
        end
        return v[15:0];
    endfunction

    // Tags may arrive out of range, so wrap with a true modulo.
    function automatic logic [7:0] next_chn(input logic [7:0] c);
        logic [8:0] s;
        s = {1'b0, c} + 9'd1;
        return 8'(s % 9'(NumChannelUsed));
    endfunction

endpackage

// File: rtl/prach_hb3_interp_delay.sv
// Fixed-depth register delay for control/tag alignment.
module prach_hb3_interp_delay #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DELAY = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DELAY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int unsigned i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/prach_hb3_interp.sv
// Half-band x2 interpolator for channel-interleaved PRACH samples, producing
// the (filtered, centre) polyphase pair and policing the channel sequence.
module prach_hb3_interp
    import prach_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din_dq,
    input  logic               din_dv,
    input  logic [7:0]         din_chn,
    input  logic               sync_in,
    output logic signed [15:0] dout_dp1,
    output logic signed [15:0] dout_dp2,
    output logic               dout_dv,
    output logic [7:0]         dout_chn,
    output logic               sync_out,
    output logic               err_chn
);

    localparam int unsigned LineLen = 3 * NumChannelUsed;

    logic signed [15:0] line_q [LineLen];
    logic signed [15:0] x1, x2, x3;

    logic signed [16:0] sa_q, sb_q;
    logic signed [35:0] pa_q, pb_q, acc_q;
    logic signed [15:0] sat_q, p1_q;
    logic signed [15:0] c_q [5];
    logic [4:0]         vld_q;
    logic signed [15:0] dp1_q, dp2_q;

    seq_state_e state_q, state_d;
    logic [7:0] exp_q, exp_d;
    logic       err_q, err_d;

    logic [9:0] ctrl_in, ctrl_out;

    assign x1 = line_q[NumChannelUsed-1];
    assign x2 = line_q[2*NumChannelUsed-1];
    assign x3 = line_q[LineLen-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LineLen; i++) begin
                line_q[i] <= '0;
            end
        end else if (din_dv) begin
            line_q[0] <= din_dq;
            for (int unsigned i = 1; i < LineLen; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    // Arithmetic stages run freely; vld_q only decides when the output registers load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q  <= '0;
            sb_q  <= '0;
            pa_q  <= '0;
            pb_q  <= '0;
            acc_q <= '0;
            sat_q <= '0;
            p1_q  <= '0;
            vld_q <= '0;
            dp1_q <= '0;
            dp2_q <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            sa_q  <= 17'(din_dq) + 17'(x3);
            sb_q  <= 17'(x1) + 17'(x2);
            pa_q  <= 36'(sa_q) * 36'(CoeA);
            pb_q  <= 36'(sb_q) * 36'(CoeB);
            acc_q <= pa_q + pb_q;
            sat_q <= sat16(acc_q[35:16]);
            p1_q  <= sat_q;
            c_q[0] <= x1;
            for (int unsigned i = 1; i < 5; i++) begin
                c_q[i] <= c_q[i-1];
            end
            vld_q <= {vld_q[3:0], din_dv};
            if (vld_q[4]) begin
                dp1_q <= p1_q;
                dp2_q <= c_q[4];
            end
        end
    end

    assign dout_dp1 = dp1_q;
    assign dout_dp2 = dp2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_HUNT;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == SEQ_HUNT && din_dv && sync_in && din_chn == '0) begin
            state_d = SEQ_TRACK;
        end
    end

    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (din_dv) begin
            case (state_q)
                SEQ_HUNT: begin
                    if (sync_in && din_chn == '0) begin
                        exp_d = 8'd1;
                    end
                end
                default: begin
                    if (sync_in && din_chn == '0) begin
                        exp_d = 8'd1;
                    end else begin
                        if (sync_in || din_chn != exp_q) begin
                            err_d = 1'b1;
                        end
                        exp_d = next_chn(din_chn);
                    end
                end
            endcase
        end
    end

    assign err_chn = err_q;

    assign ctrl_in = {sync_in & din_dv, din_dv, din_chn};

    prach_hb3_interp_delay #(
        .WIDTH(10),
        .DELAY(Latency)
    ) u_ctrl_delay (
        .clk  (clk),
        .rst_n(~rst),
        .din  (ctrl_in),
        .dout (ctrl_out)
    );

    assign sync_out = ctrl_out[9];
    assign dout_dv  = ctrl_out[8];
    assign dout_chn = ctrl_out[7:0];

endmodule
